// File: rtl/frame_rx_pkg.sv
// Shared types and sizing helpers for the framed serial receiver.
package frame_rx_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GAP  = 2'd1,
      DATA = 2'd2,
      OUT  = 2'd3
   } state_t;

   // Total bits per frame: header, all fields, and separators between fields.
   function automatic int nbits(input int hdr_bits, input int nfield,
                                input int fw, input int sep_bits);
      return hdr_bits + nfield * fw + (nfield - 1) * sep_bits;
   endfunction

   // A high run longer than this many clocks counts as the frame gap.
   function automatic int gap_thresh(input int idle_bits, input int spb);
      return idle_bits * spb - 9;
   endfunction

endpackage

// File: rtl/frame_rx_edge.sv
// Two-flop synchroniser for the serial line with rise/fall strobes.
module frame_rx_edge (
   input  logic clk_16M,
   input  logic rst,
   input  logic data_i,
   output logic f2,
   output logic rise,
   output logic fall
);

   logic f1;

   // Bring the asynchronous line into the clk_16M domain.
   always_ff @(posedge clk_16M or posedge rst) begin
      if (rst) begin
         f1 <= 1'b0;
         f2 <= 1'b0;
      end else begin
         f1 <= data_i;
         f2 <= f1;
      end
   end

   assign rise = f1 & ~f2;
   assign fall = ~f1 & f2;

endmodule

// File: rtl/frame_rx_param.sv
// Gap-qualified framed serial receiver: header check, field/separator capture.
module frame_rx_param
   import frame_rx_pkg::*;
#(
   parameter int SPB       = 16,
   parameter int IDLE_BITS = 9,
   parameter int HDR_BITS  = 2,
   parameter logic [HDR_BITS-1:0] HDR_VAL = '0,
   parameter int NFIELD    = 2,
   parameter int FW        = 8,
   parameter int SEP_BITS  = 2,
   parameter int INVERT    = 1,
   localparam int DW       = NFIELD * FW,
   localparam int SW       = (NFIELD > 1) ? (NFIELD - 1) * SEP_BITS : 1
) (
   input  logic          clk_16M,
   input  logic          rst,
   input  logic          data_i,
   output logic [DW-1:0] data_o,
   output logic [SW-1:0] sep_o,
   output logic          done,
   output logic          err
);

   localparam int NBITS  = nbits(HDR_BITS, NFIELD, FW, SEP_BITS);
   localparam int THRESH = gap_thresh(IDLE_BITS, SPB);
   localparam int RUN_W  = $clog2(THRESH + 2);
   localparam int SMP_W  = $clog2(SPB);
   localparam int BIT_W  = (NBITS > 1) ? $clog2(NBITS) : 1;

   localparam logic [RUN_W-1:0] RUN_THR  = RUN_W'(THRESH);
   localparam logic [SMP_W-1:0] SMP_A    = SMP_W'(SPB / 2 - 2);
   localparam logic [SMP_W-1:0] SMP_B    = SMP_W'(SPB / 2 - 1);
   localparam logic [SMP_W-1:0] SMP_MID  = SMP_W'(SPB / 2);
   localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(SPB - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);

   state_t               state_reg, state_next;
   logic [RUN_W-1:0]     run_reg;
   logic [SMP_W-1:0]     smp_reg;
   logic [BIT_W-1:0]     bit_reg;
   logic                 samp_a_reg, samp_b_reg;
   logic [NBITS-1:0]     cap_reg;
   logic                 f2, rise, fall;
   logic                 vote;
   logic                 hdr_ok;
   logic [DW-1:0]        data_w;
   logic [SW-1:0]        sep_w;

   frame_rx_edge u_edge (
      .clk_16M (clk_16M),
      .rst     (rst),
      .data_i  (data_i),
      .f2      (f2),
      .rise    (rise),
      .fall    (fall)
   );

   assign vote   = (samp_a_reg & samp_b_reg) | (samp_a_reg & f2) | (samp_b_reg & f2);
   assign hdr_ok = (cap_reg[HDR_BITS-1:0] == HDR_VAL);

   // Unpack the capture register: field 0 follows the header, each later
   // field is preceded by its separator group.
   for (genvar gi = 0; gi < NFIELD; gi++) begin : g_field
      localparam int OFF = (gi == 0) ? HDR_BITS
                                     : HDR_BITS + FW + (gi - 1) * (SEP_BITS + FW) + SEP_BITS;
      if (INVERT != 0) begin : g_inv
         assign data_w[gi*FW +: FW] = ~cap_reg[OFF +: FW];
      end else begin : g_raw
         assign data_w[gi*FW +: FW] = cap_reg[OFF +: FW];
      end
   end

   if (NFIELD > 1) begin : g_sep
      for (genvar gi = 1; gi < NFIELD; gi++) begin : g_grp
         localparam int OFF = HDR_BITS + FW + (gi - 1) * (SEP_BITS + FW);
         assign sep_w[(gi-1)*SEP_BITS +: SEP_BITS] = cap_reg[OFF +: SEP_BITS];
      end
   end else begin : g_nosep
      assign sep_w = '0;
   end

   // State register.
   always_ff @(posedge clk_16M or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // Next-state decode; done/err are asserted for the single OUT cycle.
   always_comb begin
      state_next = state_reg;
      done       = 1'b0;
      err        = 1'b0;
      case (state_reg)
         IDLE: if (rise) state_next = GAP;
         GAP:  if (fall) state_next = (run_reg > RUN_THR) ? DATA : IDLE;
         DATA: if (smp_reg == SMP_MID && bit_reg == BIT_LAST) state_next = OUT;
         OUT: begin
            done       = hdr_ok;
            err        = ~hdr_ok;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Run, sample and bit counters plus majority-vote bit capture.
   always_ff @(posedge clk_16M or posedge rst) begin
      if (rst) begin
         run_reg    <= '0;
         smp_reg    <= '0;
         bit_reg    <= '0;
         samp_a_reg <= 1'b0;
         samp_b_reg <= 1'b0;
         cap_reg    <= '0;
      end else begin
         case (state_reg)
            IDLE: if (rise) run_reg <= '0;
            GAP: begin
               if (run_reg != '1) run_reg <= run_reg + 1'b1;
               if (fall) begin
                  smp_reg <= '0;
                  bit_reg <= '0;
               end
            end
            DATA: begin
               // Edges on the line are ignored here: timing is free-running.
               if (smp_reg == SMP_LAST) begin
                  smp_reg <= '0;
                  bit_reg <= bit_reg + 1'b1;
               end else begin
                  smp_reg <= smp_reg + 1'b1;
               end
               if (smp_reg == SMP_A)   samp_a_reg       <= f2;
               if (smp_reg == SMP_B)   samp_b_reg       <= f2;
               if (smp_reg == SMP_MID) cap_reg[bit_reg] <= vote;
            end
            default: ;
         endcase
      end
   end

   // Publish fields and separators only for frames with a matching header;
   // they appear on the edge that ends the done pulse and hold until the next.
   always_ff @(posedge clk_16M or posedge rst) begin
      if (rst) begin
         data_o <= '0;
         sep_o  <= '0;
      end else if (state_reg == OUT && hdr_ok) begin
         data_o <= data_w;
         sep_o  <= sep_w;
      end
   end

endmodule

// File: tb/tb_frame_rx_param.sv
// Self-checking bench for frame_rx_param (default and small-parameter instances).
module tb_frame_rx_param;

   logic        clk_16M = 1'b0;
   logic        rst = 1'b1;
   logic        d0 = 1'b0;
   logic        d1 = 1'b0;
   logic [15:0] data0;
   logic [1:0]  sep0;
   logic        done0, err0;
   logic [11:0] data1;
   logic [1:0]  sep1;
   logic        done1, err1;

   int checks = 0;
   int failures = 0;
   int done_cnt0 = 0, err_cnt0 = 0, done_cnt1 = 0, err_cnt1 = 0, both_cnt = 0;
   int lat_off;
   bit txq[$];

   always #5 clk_16M = ~clk_16M;

   frame_rx_param dut (
      .clk_16M (clk_16M), .rst (rst), .data_i (d0),
      .data_o (data0), .sep_o (sep0), .done (done0), .err (err0)
   );

   frame_rx_param #(.SPB(8), .NFIELD(3), .FW(4), .SEP_BITS(1), .INVERT(0)) dut2 (
      .clk_16M (clk_16M), .rst (rst), .data_i (d1),
      .data_o (data1), .sep_o (sep1), .done (done1), .err (err1)
   );

   // Pulse counters sampled on the falling edge.
   always @(negedge clk_16M) begin
      if (done0) done_cnt0++;
      if (err0)  err_cnt0++;
      if (done1) done_cnt1++;
      if (err1)  err_cnt1++;
      if ((done0 && err0) || (done1 && err1)) both_cnt++;
   end

   task automatic tick();
      @(posedge clk_16M);
      #1;
   endtask

   task automatic set_line(input int which, input logic v);
      if (which == 0) d0 = v;
      else            d1 = v;
   endtask

   task automatic push(input int val, input int n);
      for (int i = 0; i < n; i++) txq.push_back(bit'((val >> i) & 1));
   endtask

   // Drive low, a high gap, then the queued bits (LSB-first groups), then idle low.
   task automatic send(input int which, input int spb, input int gap,
                       input int glitch_bit, input int abort_at);
      int   n;
      logic v;
      n = txq.size();
      lat_off = -1;
      set_line(which, 1'b0);
      repeat (4) tick();
      set_line(which, 1'b1);
      repeat (gap) tick();
      for (int i = 0; i < n; i++) begin
         if (i == abort_at) begin
            rst = 1'b1;
            repeat (5) tick();
            rst = 1'b0;
            break;
         end
         for (int c = 0; c < spb; c++) begin
            v = txq[i];
            if (i == glitch_bit && c == spb / 2 - 1) v = ~v;
            set_line(which, v);
            tick();
            if (i == n - 1 && lat_off < 0 &&
                ((which == 0) ? (done0 | err0) : (done1 | err1)))
               lat_off = c;
         end
      end
      set_line(which, 1'b0);
      repeat (20) tick();
      txq.delete();
   endtask

   // Reference: each field is 255 minus its raw value, field k in byte k.
   function automatic logic [15:0] model0(input int f0, input int f1);
      int v;
      v = (255 - (f1 & 255)) * 256 + (255 - (f0 & 255));
      return 16'(v);
   endfunction

   function automatic logic [11:0] model1(input int f0, input int f1, input int f2);
      return 12'((f0 & 15) + (f1 & 15) * 16 + (f2 & 15) * 256);
   endfunction

   task automatic frame0(input int hdr, input int f0, input int sep, input int f1);
      push(hdr, 2); push(f0, 8); push(sep, 2); push(f1, 8);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      checks++; if (data0 !== 16'h0) begin failures++; $display("FAIL reset_data0 got=%h exp=0000", data0); end
      checks++; if (sep0 !== 2'b00) begin failures++; $display("FAIL reset_sep0 got=%b exp=00", sep0); end
      checks++; if (done0 !== 1'b0 || err0 !== 1'b0) begin failures++; $display("FAIL reset_pulse0 done=%b err=%b exp=0/0", done0, err0); end
      checks++; if (data1 !== 12'h0 || sep1 !== 2'b00) begin failures++; $display("FAIL reset_dut2 data=%h sep=%b exp=000/00", data1, sep1); end
      rst = 1'b0;
      tick();
      $display("test_reset: done");
   endtask

   task automatic test_basic();
      int dc, ec;
      dc = done_cnt0; ec = err_cnt0;
      frame0(0, 'h5A, 1, 'h0F);
      send(0, 16, 150, -1, -1);
      checks++; if (done_cnt0 - dc !== 1 || err_cnt0 - ec !== 0) begin failures++; $display("FAIL basic_pulses done=%0d err=%0d exp=1/0", done_cnt0 - dc, err_cnt0 - ec); end
      checks++; if (data0 !== 16'hF0A5) begin failures++; $display("FAIL basic_data got=%h exp=f0a5", data0); end
      checks++; if (sep0 !== 2'b01) begin failures++; $display("FAIL basic_sep got=%b exp=01", sep0); end
      checks++; if (lat_off !== 10) begin failures++; $display("FAIL basic_latency got_offset=%0d exp=10", lat_off); end
      $display("test_basic: data=%h sep=%b", data0, sep0);
   endtask

   task automatic test_short_gap();
      int dc, ec, f0, f1, s;
      logic [15:0] prev;
      prev = data0; dc = done_cnt0; ec = err_cnt0;
      frame0(0, 'h33, 2, 'h44);
      send(0, 16, 130, -1, -1);
      checks++; if (done_cnt0 - dc !== 0 || err_cnt0 - ec !== 0) begin failures++; $display("FAIL shortgap_pulses done=%0d err=%0d exp=0/0", done_cnt0 - dc, err_cnt0 - ec); end
      checks++; if (data0 !== prev) begin failures++; $display("FAIL shortgap_hold got=%h exp=%h", data0, prev); end
      f0 = $urandom_range(0, 255); f1 = $urandom_range(0, 255); s = $urandom_range(0, 3);
      dc = done_cnt0;
      frame0(0, f0, s, f1);
      send(0, 16, 150, -1, -1);
      checks++; if (done_cnt0 - dc !== 1) begin failures++; $display("FAIL shortgap_next_done got=%0d exp=1", done_cnt0 - dc); end
      checks++; if (data0 !== model0(f0, f1)) begin failures++; $display("FAIL shortgap_next_data got=%h exp=%h", data0, model0(f0, f1)); end
      $display("test_short_gap: data=%h", data0);
   endtask

   task automatic test_gap_boundary();
      int dc;
      dc = done_cnt0;
      frame0(0, 'h81, 3, 'h7E);
      send(0, 16, 136, -1, -1);
      checks++; if (done_cnt0 - dc !== 0) begin failures++; $display("FAIL gap136_done got=%0d exp=0", done_cnt0 - dc); end
      dc = done_cnt0;
      frame0(0, 'h81, 3, 'h7E);
      send(0, 16, 137, -1, -1);
      checks++; if (done_cnt0 - dc !== 1) begin failures++; $display("FAIL gap137_done got=%0d exp=1", done_cnt0 - dc); end
      checks++; if (data0 !== model0('h81, 'h7E) || sep0 !== 2'b11) begin failures++; $display("FAIL gap137_data got=%h/%b exp=%h/11", data0, sep0, model0('h81, 'h7E)); end
      $display("test_gap_boundary: data=%h", data0);
   endtask

   task automatic test_header_err();
      int dc, ec;
      logic [15:0] prev;
      logic [1:0]  prev_sep;
      prev = data0; prev_sep = sep0; dc = done_cnt0; ec = err_cnt0;
      frame0(2, 'hAA, 2, 'h55);   // header bits sent 0 then 1
      send(0, 16, 150, -1, -1);
      checks++; if (err_cnt0 - ec !== 1 || done_cnt0 - dc !== 0) begin failures++; $display("FAIL hdr_pulses err=%0d done=%0d exp=1/0", err_cnt0 - ec, done_cnt0 - dc); end
      checks++; if (data0 !== prev || sep0 !== prev_sep) begin failures++; $display("FAIL hdr_hold got=%h/%b exp=%h/%b", data0, sep0, prev, prev_sep); end
      checks++; if (lat_off !== 10) begin failures++; $display("FAIL hdr_latency got_offset=%0d exp=10", lat_off); end
      $display("test_header_err: data=%h", data0);
   endtask

   task automatic test_glitch();
      int dc;
      dc = done_cnt0;
      frame0(0, 'hC3, 2, 'h96);
      send(0, 16, 150, 5, -1);
      checks++; if (done_cnt0 - dc !== 1) begin failures++; $display("FAIL glitch_done got=%0d exp=1", done_cnt0 - dc); end
      checks++; if (data0 !== model0('hC3, 'h96) || sep0 !== 2'b10) begin failures++; $display("FAIL glitch_data got=%h/%b exp=%h/10", data0, sep0, model0('hC3, 'h96)); end
      $display("test_glitch: data=%h", data0);
   endtask

   task automatic test_reset_midframe();
      int dc, ec;
      dc = done_cnt0; ec = err_cnt0;
      frame0(0, 'h11, 3, 'h22);
      send(0, 16, 150, -1, 10);
      checks++; if (data0 !== 16'h0) begin failures++; $display("FAIL midrst_cleared got=%h exp=0000", data0); end
      frame0(0, 'h3C, 1, 'hE7);
      send(0, 16, 150, -1, -1);
      checks++; if (done_cnt0 - dc !== 1 || err_cnt0 - ec !== 0) begin failures++; $display("FAIL midrst_pulses done=%0d err=%0d exp=1/0", done_cnt0 - dc, err_cnt0 - ec); end
      checks++; if (data0 !== model0('h3C, 'hE7) || sep0 !== 2'b01) begin failures++; $display("FAIL midrst_data got=%h/%b exp=%h/01", data0, sep0, model0('h3C, 'hE7)); end
      $display("test_reset_midframe: data=%h", data0);
   endtask

   task automatic test_random();
      int dc, f0, f1, s, g;
      for (int k = 0; k < 5; k++) begin
         f0 = $urandom_range(0, 255); f1 = $urandom_range(0, 255);
         s = $urandom_range(0, 3); g = $urandom_range(140, 220);
         dc = done_cnt0;
         frame0(0, f0, s, f1);
         send(0, 16, g, -1, -1);
         checks++;
         if (done_cnt0 - dc !== 1 || data0 !== model0(f0, f1) || sep0 !== 2'(s)) begin
            failures++;
            $display("FAIL random_%0d done=%0d data=%h sep=%b exp=1/%h/%b", k, done_cnt0 - dc, data0, sep0, model0(f0, f1), 2'(s));
         end
         $display("test_random[%0d]: f0=%h f1=%h sep=%0d gap=%0d data=%h", k, f0, f1, s, g, data0);
      end
   endtask

   task automatic test_param();
      int dc, f0, f1, f2, s1, s2;
      dc = done_cnt1;
      push(0, 2); push('h3, 4); push(1, 1); push('hC, 4); push(0, 1); push('h9, 4);
      send(1, 8, 80, -1, -1);
      checks++; if (done_cnt1 - dc !== 1 || err_cnt1 !== 0) begin failures++; $display("FAIL param_pulses done=%0d err=%0d exp=1/0", done_cnt1 - dc, err_cnt1); end
      checks++; if (data1 !== 12'h9C3 || sep1 !== 2'b01) begin failures++; $display("FAIL param_data got=%h/%b exp=9c3/01", data1, sep1); end
      checks++; if (lat_off !== 6) begin failures++; $display("FAIL param_latency got_offset=%0d exp=6", lat_off); end
      for (int k = 0; k < 3; k++) begin
         f0 = $urandom_range(0, 15); f1 = $urandom_range(0, 15); f2 = $urandom_range(0, 15);
         s1 = $urandom_range(0, 1); s2 = $urandom_range(0, 1);
         dc = done_cnt1;
         push(0, 2); push(f0, 4); push(s1, 1); push(f1, 4); push(s2, 1); push(f2, 4);
         send(1, 8, $urandom_range(70, 120), -1, -1);
         checks++;
         if (done_cnt1 - dc !== 1 || data1 !== model1(f0, f1, f2) || sep1 !== 2'(s1 + 2 * s2)) begin
            failures++;
            $display("FAIL param_random_%0d done=%0d data=%h sep=%b exp=1/%h/%b", k, done_cnt1 - dc, data1, sep1, model1(f0, f1, f2), 2'(s1 + 2 * s2));
         end
         $display("test_param[%0d]: data=%h sep=%b", k, data1, sep1);
      end
   endtask

   task automatic test_exclusive();
      checks++; if (both_cnt !== 0) begin failures++; $display("FAIL done_err_overlap got=%0d exp=0", both_cnt); end
      checks++; if (done_cnt1 !== 4) begin failures++; $display("FAIL dut2_total_done got=%0d exp=4", done_cnt1); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_short_gap();
      test_gap_boundary();
      test_header_err();
      test_glitch();
      test_reset_midframe();
      test_random();
      test_param();
      test_exclusive();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
